// File: rtl/sdram_port_pkg.sv
// sdram_port_pkg: shared widths, read-FSM states and the pointer wrap helper
package sdram_port_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_READY} state_t;
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] base, input logic [31:0] max);
    return ptr == max ? base : ptr + 32'd1;
  endfunction
endpackage

// File: rtl/dp_ram_sync.sv
// dp_ram_sync: simple dual-port RAM, one write port and one enabled registered read port
module dp_ram_sync #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sdram_port_responder.sv
// sdram_port_responder: wrap-around loopback buffer for the SDRAM host FIFO port with show-ahead read; ERR_INJECT_EN adds iINJ_ENABLE/iINJ_ADDR bit-0 corruption
module sdram_port_responder
  import sdram_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOAD,
  input  logic [ADDR_W-1:0] iBASE_ADDR,
  input  logic [ADDR_W-1:0] iMAX_ADDR,
  input  logic              iWR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic              iRD,
`ifdef ERR_INJECT_EN
  input  logic              iINJ_ENABLE,
  input  logic [ADDR_W-1:0] iINJ_ADDR,
`endif
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_EMPTY,
  output logic [ADDR_W:0]   oWORDS,
  output logic              oFULL,
  output logic              oOVERFLOW,
  output logic              oUNDERFLOW
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_adv, rptr_adv, raddr;
  logic [ADDR_W:0] words_q, words_d, span;
  logic full_q, full_d, ovf_q, ovf_d, udf_q, udf_d;
  logic ready, wr_ok, pop, more, fetch, we, re, inj;
  logic [DATA_W-1:0] ram_q;
  always_comb begin
    span = {1'b0, iMAX_ADDR} - {1'b0, iBASE_ADDR} + (ADDR_W+1)'(1);
    ready = state_q == S_READY;
    wr_ok = iWR && !full_q;
    pop = iRD && ready;
    more = pop && words_q > (ADDR_W+1)'(1);
    fetch = state_q == S_EMPTY && words_q != '0;
    wptr_adv = ADDR_W'(next_ptr(32'(wptr_q), 32'(iBASE_ADDR), 32'(iMAX_ADDR)));
    rptr_adv = ADDR_W'(next_ptr(32'(rptr_q), 32'(iBASE_ADDR), 32'(iMAX_ADDR)));
    we = wr_ok && !iLOAD;
    re = (fetch || more) && !iLOAD;
    raddr = more ? rptr_adv : rptr_q;
    words_d = iLOAD ? '0 : (wr_ok && !pop) ? words_q + (ADDR_W+1)'(1) : (pop && !wr_ok) ? words_q - (ADDR_W+1)'(1) : words_q;
    full_d = !iLOAD && words_d == span;
    wptr_d = iLOAD ? iBASE_ADDR : wr_ok ? wptr_adv : wptr_q;
    rptr_d = iLOAD ? iBASE_ADDR : pop ? rptr_adv : rptr_q;
    state_d = iLOAD ? S_EMPTY : fetch ? S_FETCH : state_q == S_FETCH ? S_READY : (pop && !more) ? S_EMPTY : state_q;
    ovf_d = !iLOAD && (ovf_q || (iWR && full_q));
    udf_d = !iLOAD && (udf_q || (iRD && !ready));
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_EMPTY;
      wptr_q <= '0;
      rptr_q <= '0;
      words_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      words_q <= words_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  dp_ram_sync #(.DW(DATA_W), .AW(ADDR_W)) u_ram (
    .clk(iCLK), .we(we), .waddr(wptr_q), .wdata(iWR_DATA), .re(re), .raddr(raddr), .rdata(ram_q)
  );
`ifdef ERR_INJECT_EN
  assign inj = iINJ_ENABLE && rptr_q == iINJ_ADDR;
`else
  assign inj = 1'b0;
`endif
  assign oRD_EMPTY = !ready;
  assign oRD_DATA = ready ? ram_q ^ DATA_W'(inj) : '0;
  assign oWORDS = words_q;
  assign oFULL = full_q;
  assign oOVERFLOW = ovf_q;
  assign oUNDERFLOW = udf_q;
endmodule
